// File: rtl/vec_op_sequencer.sv
// Sequencer that turns one vector job (two loads, add/mul, one or two stores)
// into a timed CPU command stream with settle NOPs, then pulses done.
module vec_op_sequencer #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_mul,
  input  logic              job_store_hi,
  input  logic [ADDR_W-1:0] job_src1,
  input  logic [ADDR_W-1:0] job_src2,
  input  logic [ADDR_W-1:0] job_dst,
  output logic [2:0]        instruction,
  output logic [1:0]        reg_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_NOP   = 3'b101;

  // Counter holds the wait cycles remaining after the current one, so a
  // *_W state lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WC_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [3:0] {
    IDLE, LD1, LD1_W, LD2, LD2_W, EXEC, EX_W, ST_LO, ST_HI, DONE
  } state_t;

  state_t            state, state_next;
  logic [3:0]        wc, wc_next;
  logic              mul_q, store_hi_q;
  logic [ADDR_W-1:0] src2_q, dst_q;

  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    wc_next    = (wc != 4'd0) ? wc - 4'd1 : 4'd0;
    case (state)
      IDLE:  if (job_valid) state_next = LD1;
      LD1:   begin state_next = NO_WAIT ? LD2 : LD1_W; wc_next = WC_INIT; end
      LD1_W: if (wc == 4'd0) state_next = LD2;
      LD2:   begin state_next = NO_WAIT ? EXEC : LD2_W; wc_next = WC_INIT; end
      LD2_W: if (wc == 4'd0) state_next = EXEC;
      EXEC:  begin state_next = NO_WAIT ? ST_LO : EX_W; wc_next = WC_INIT; end
      EX_W:  if (wc == 4'd0) state_next = ST_LO;
      ST_LO: state_next = store_hi_q ? ST_HI : DONE;
      ST_HI: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wc          <= 4'd0;
      mul_q       <= 1'b0;
      store_hi_q  <= 1'b0;
      src2_q      <= '0;
      dst_q       <= '0;
      instruction <= OP_NOP;
      reg_addr    <= 2'b00;
      mem_address <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_next;
      wc    <= wc_next;
      if (state == IDLE && job_valid) begin
        mul_q      <= job_mul;
        store_hi_q <= job_store_hi;
        src2_q     <= job_src2;
        dst_q      <= job_dst;
      end
      instruction <= OP_NOP;
      reg_addr    <= 2'b00;
      mem_address <= '0;
      done        <= 1'b0;
      // Outputs are decoded from the upcoming state; LD1 reads src1 straight
      // from the port because it is issued on the accept edge itself.
      case (state_next)
        LD1:   begin instruction <= OP_LOAD;  reg_addr <= 2'b00; mem_address <= job_src1; end
        LD2:   begin instruction <= OP_LOAD;  reg_addr <= 2'b01; mem_address <= src2_q; end
        EXEC:  instruction <= mul_q ? OP_MUL : OP_ADD;
        ST_LO: begin instruction <= OP_STORE; reg_addr <= 2'b11; mem_address <= dst_q; end
        ST_HI: begin instruction <= OP_STORE; reg_addr <= 2'b10; mem_address <= dst_q + ADDR_W'(1); end
        DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
